// File: rtl/fb_ddr3_master.sv
// Avalon-MM master for the frame buffer DDR3 port.
// Writes stream pixel words to sequential addresses. Reads stream a whole frame
// back through a response FIFO. Reads win arbitration of the shared command bus.
module fb_ddr3_master #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 29,
    parameter int FRAME_WORDS = 1024,
    parameter int WR_BASE     = 0,
    parameter int RD_BASE     = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    rd_start,
    output logic                    rd_busy,
    output logic                    wr_done,
    output logic                    rd_done,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic [2:0]              avm_burstcount,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    output logic                    avm_write,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]   avm_readdata,
    input  logic                    avm_readdatavalid
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] WR_OFS  = ADDR_WIDTH'(WR_BASE);
    localparam logic [ADDR_WIDTH-1:0] RD_OFS  = ADDR_WIDTH'(RD_BASE);
    localparam logic [PW-1:0]         IDX_TOP = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_t;

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, pop_cnt;
    logic [CW-1:0]         outstanding, fifo_count, fifo_next;
    logic [PW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic                  rd_want, rd_acc, wr_acc, push, pop;

    // Credit: never issue a read whose response could not find a FIFO slot.
    // Gating with rst keeps every command/handshake output low during reset.
    assign rd_want = rst && (state == RD_ISSUE) &&
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
    assign avm_read       = rd_want;
    assign avm_write      = rst && in_valid && !rd_want;
    assign in_ready       = rst && !avm_waitrequest && !rd_want;
    assign avm_address    = rd_want ? (RD_OFS + rd_ptr) : (WR_OFS + wr_ptr);
    assign avm_burstcount = 3'd1;
    assign avm_writedata  = in_data;
    assign avm_byteenable = '1;

    assign rd_acc   = avm_read && !avm_waitrequest;
    assign wr_acc   = in_valid && in_ready;
    assign push     = avm_readdatavalid;
    assign pop      = out_valid && out_ready;
    assign out_data = fifo_mem[rd_idx];

    // Next FIFO occupancy, shared by the count and the registered out_valid.
    always_comb begin
        fifo_next = fifo_count + CW'(push) - CW'(pop);
    end

    // Write pointer walks the frame and wraps; wr_done follows the last accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= wr_acc && (wr_ptr == LAST);
            if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Read FSM: issue the frame, then drain until the final word leaves the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RD_IDLE;
            rd_ptr  <= '0;
            pop_cnt <= '0;
            rd_busy <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                RD_IDLE: if (rd_start) begin
                    state   <= RD_ISSUE;
                    rd_busy <= 1'b1;
                end
                RD_ISSUE: if (rd_acc) begin
                    if (rd_ptr == LAST) begin
                        rd_ptr <= '0;
                        state  <= RD_DRAIN;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
            // The last pop always trails the last accept, so it may override the case above.
            if (pop) begin
                if (pop_cnt == LAST) begin
                    pop_cnt <= '0;
                    state   <= RD_IDLE;
                    rd_busy <= 1'b0;
                    rd_done <= 1'b1;
                end else begin
                    pop_cnt <= pop_cnt + 1'b1;
                end
            end
        end
    end

    // In-flight and queued response accounting; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            fifo_count  <= '0;
            out_valid   <= 1'b0;
            wr_idx      <= '0;
            rd_idx      <= '0;
        end else begin
            outstanding <= outstanding + CW'(rd_acc) - CW'(push);
            fifo_count  <= fifo_next;
            out_valid   <= (fifo_next != '0);
            if (push) wr_idx <= (wr_idx == IDX_TOP) ? '0 : wr_idx + 1'b1;
            if (pop)  rd_idx <= (rd_idx == IDX_TOP) ? '0 : rd_idx + 1'b1;
        end
    end

    // Response storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx] <= avm_readdata;
    end
endmodule

// File: tb/tb_fb_ddr3_master.sv
// Bench for fb_ddr3_master: scoreboarded write commands and read-stream data,
// with a one-cycle-latency memory responder and protocol monitors.
module tb_fb_ddr3_master;
    localparam int DW = 32, AW = 8, FW = 16, FD = 4;

    logic          clk = 1'b0, rst = 1'b0;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready, rd_start, rd_busy, wr_done, rd_done;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic [AW-1:0] avm_address;
    logic [2:0]    avm_burstcount;
    logic [DW-1:0] avm_writedata, avm_readdata;
    logic [DW/8-1:0] avm_byteenable;
    logic          avm_write, avm_read, avm_waitrequest, avm_readdatavalid;

    always #5 clk = ~clk;

    fb_ddr3_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(FW),
                     .WR_BASE(0), .RD_BASE(0), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rd_start(rd_start), .rd_busy(rd_busy), .wr_done(wr_done), .rd_done(rd_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_write(avm_write), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboards and expected memory contents (from what the bench sent).
    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    rq[$];
    logic [DW-1:0]    exp_mem [FW];
    int               exp_wa = 0;

    // Memory responder state.
    logic [DW-1:0] mem [256];
    logic          pend = 1'b0;
    logic [DW-1:0] pdata = '0;

    // Monitor state.
    int cyc = 0, wr15_cyc = -100, first_rd_cyc = -1, first_ov_cyc = -1;
    int n_wr_done = 0, n_rd_done = 0, n_rd_acc = 0, n_wr_acc = 0, occ = 0, n_stall = 0;
    logic          p_hold = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Read responses appear one cycle after the accepting edge.
    always @(posedge clk) begin
        #1;
        avm_readdatavalid = pend && rst;
        avm_readdata      = pdata;
    end

    // All sampling happens mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        logic             pp;
        if (!rst) begin
            pend = 1'b0; occ = 0; p_hold = 1'b0;
        end else begin
            if (avm_read && avm_write) chk("rd_wr_overlap", 1, 0);
            if (avm_read && in_ready)  chk("in_ready_during_read", in_ready, 0);
            if (avm_read && in_valid)  n_stall++;
            if (p_hold) begin
                chk("hold_read", avm_read, p_rd);
                chk("hold_write", avm_write, p_wr);
                chk("hold_addr", avm_address, p_addr);
                if (p_wr) chk("hold_wdata", avm_writedata, p_wdata);
            end
            p_hold  = avm_waitrequest && (avm_read || avm_write);
            p_rd    = avm_read;  p_wr = avm_write;
            p_addr  = avm_address; p_wdata = avm_writedata;
            pend    = avm_read && !avm_waitrequest;
            pdata   = mem[avm_address];
            if (pend) n_rd_acc++;
            if (avm_write && !avm_waitrequest) begin
                mem[avm_address] = avm_writedata;
                n_wr_acc++;
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_addr", avm_address, e[AW+DW-1:DW]);
                    chk("wr_data", avm_writedata, e[DW-1:0]);
                end
                if (avm_address == AW'(FW - 1)) wr15_cyc = cyc;
            end
            if (avm_read && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (wr_done) begin n_wr_done++; chk("wr_done_latency", cyc - wr15_cyc, 1); end
            if (rd_done) n_rd_done++;
            if (avm_readdatavalid && occ >= FD) chk("fifo_push_when_full", occ, FD - 1);
            pp = out_valid && out_ready;
            if (pp) begin
                if (rq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", out_data, rq.pop_front());
            end
            occ = occ + int'(avm_readdatavalid) - int'(pp);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        wq.push_back({AW'(exp_wa), d});
        exp_mem[exp_wa] = d;
        exp_wa = (exp_wa + 1) % FW;
        in_valid = 1'b1; in_data = d;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready) begin @(posedge clk); #1; in_valid = 1'b0; return; end
        end
        chk("wr_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic arm_read();
        first_rd_cyc = -1; first_ov_cyc = -1; n_rd_done = 0; n_rd_acc = 0;
        for (int i = 0; i < FW; i++) rq.push_back(exp_mem[i]);
    endtask

    task automatic wait_rd_done();
        for (int k = 0; k < 600 && n_rd_done == 0; k++) step(1);
        if (n_rd_done == 0) chk("rd_done_timeout", 0, 1);
        step(3);
        chk("rd_done_count", n_rd_done, 1);
        chk("rd_queue_left", rq.size(), 0);
        chk("rd_busy_after", rd_busy, 0);
        chk("rd_accepts", n_rd_acc, FW);
    endtask

    initial begin
        int t0, s0;
        in_valid = 0; in_data = '0; rd_start = 0; out_ready = 1;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rd_busy", rd_busy, 0);
        step(3); rst = 1; step(1);

        // Reset in the middle of a frame, with a write pending.
        for (int i = 0; i < 5; i++) send_word(DW'(100 + i));
        rst = 0; in_valid = 1; in_data = 'hDEAD;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_avm_write", avm_write, 0);
        chk("arst_avm_read", avm_read, 0);
        chk("arst_wr_done", wr_done, 0);
        chk("arst_rd_done", rd_done, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_rd_busy", rd_busy, 0);
        in_valid = 0;
        step(2); #2; rst = 1; #1;
        chk("post_rst_in_ready", in_ready, 1);
        exp_wa = 0;
        step(1);

        // 17 words: addresses 0..15 then wrap to 0, one wr_done.
        n_wr_done = 0;
        for (int i = 0; i < 17; i++) send_word(DW'(i));
        step(3);
        chk("wr_done_count", n_wr_done, 1);
        chk("wr_queue_left", wq.size(), 0);

        // Frame read with immediate consumption; expected data follows the
        // last writes, so address 0 holds 16.
        arm_read();
        rd_start = 1; t0 = cyc; step(1); rd_start = 0;
        chk("rd_busy_set", rd_busy, 1);
        wait_rd_done();
        chk("rd_first_cmd", first_rd_cyc - t0, 1);
        chk("rd_first_valid", first_ov_cyc - t0, 3);

        // Consumer stalled: credit limits reads in flight to the FIFO depth.
        arm_read();
        out_ready = 0;
        rd_start = 1; step(1); rd_start = 0;
        step(20);
        chk("credit_reads", n_rd_acc, FD);
        chk("credit_read_low", avm_read, 0);
        chk("credit_out_valid", out_valid, 1);
        out_ready = 1;
        wait_rd_done();

        // Writes held against a read frame: stalled, none lost or duplicated.
        // Rewriting current contents keeps the read expectation fixed.
        arm_read();
        n_stall = 0; s0 = n_wr_acc;
        fork
            begin rd_start = 1; step(1); rd_start = 0; wait_rd_done(); end
            for (int k = 0; k < 20; k++) send_word(exp_mem[exp_wa]);
        join
        step(2);
        chk("wr_stall_seen", n_stall > 0, 1);
        chk("wr_count_during_rd", n_wr_acc - s0, 20);
        chk("wr_queue_left2", wq.size(), 0);

        // Waitrequest during writes.
        s0 = n_wr_acc;
        fork
            for (int k = 0; k < 8; k++) send_word(DW'(200 + k));
            begin step(2); avm_waitrequest = 1; step(5); avm_waitrequest = 0; end
        join
        step(2);
        chk("wr_count_wait", n_wr_acc - s0, 8);
        chk("wr_queue_left3", wq.size(), 0);

        // Waitrequest during reads.
        arm_read();
        rd_start = 1; step(3); rd_start = 0;
        avm_waitrequest = 1; step(5); avm_waitrequest = 0;
        wait_rd_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
